// File: rtl/rx_arb_pkg.sv
// Shared definitions for the RX frame arbiter: state encoding, port-index width
// helper, default watchdog limit and statistics counter width.
package rx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT_CYC = 1024;
    localparam int STAT_W              = 16;

    function automatic int port_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rx_arb_skid.sv
// Two-entry byte+last skid buffer: unconditional push (caller guarantees room),
// occupancy report and valid/ready pop. Head entry holds steady until popped.
module rx_arb_skid
    import rx_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       push_last,
    output logic [1:0] occupancy,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready
);

    logic [8:0] mem_q [2];
    logic [8:0] mem_d [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pop, push_ok;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q][7:0];
    assign out_last  = mem_q[rd_ptr_q][8];
    assign occupancy = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        pop      = out_valid && out_ready;
        push_ok  = push && ((cnt_q != 2'd2) || pop);
        if (push_ok) begin
            mem_d[wr_ptr_q] = {push_last, push_data};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + 2'(push_ok) - 2'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_frame_arbiter.sv
// Frame-granular round-robin arbiter from per-PHY RX FIFOs to one MAC ingress,
// with starvation watchdog. Optional per-port statistics under RX_ARB_STATS_EN.
module rx_frame_arbiter
    import rx_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int PORT_W      = port_idx_w(NUM_PORTS),
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PORTS-1:0]   rx_frame_exist,
    input  logic [NUM_PORTS-1:0]   rx_empty,
    input  logic [8*NUM_PORTS-1:0] rx_dout,
    input  logic [NUM_PORTS-1:0]   rx_eod,
    output logic [NUM_PORTS-1:0]   rx_rden,
    output logic [7:0]             dn_data,
    output logic                   dn_valid,
    output logic                   dn_last,
    output logic [PORT_W-1:0]      dn_port,
    input  logic                   dn_ready,
    output logic                   dn_abort,
    output logic                   busy
`ifdef RX_ARB_STATS_EN
    ,
    input  logic [PORT_W-1:0]      stat_sel,
    output logic [15:0]            stat_frames,
    output logic [15:0]            stat_aborts
`endif
);

    arb_state_e        state_q, state_d;
    logic [PORT_W-1:0] grant_q, grant_d;
    logic [PORT_W-1:0] last_grant_q, last_grant_d;
    logic [PORT_W-1:0] scan_idx;
    logic              inflight_q, inflight_d;
    logic              eod_done_q, eod_done_d;
    logic              aborted_q, aborted_d;
    logic [15:0]       wdog_q, wdog_d;
    logic [7:0]        dout_arr [NUM_PORTS];
    logic              rd_en, skid_push, skid_pop, skid_valid, skid_last;
    logic              eod_now, room, found;
    logic [7:0]        skid_data;
    logic [1:0]        skid_occ;
    logic [2:0]        occ;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign dout_arr[g] = rx_dout[8*g +: 8];
        assign rx_rden[g]  = rd_en && (grant_q == PORT_W'(g));
    end

    rx_arb_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (skid_push),
        .push_data (dout_arr[grant_q]),
        .push_last (rx_eod[grant_q]),
        .occupancy (skid_occ),
        .out_valid (skid_valid),
        .out_data  (skid_data),
        .out_last  (skid_last),
        .out_ready (dn_ready)
    );

    assign dn_valid = skid_valid;
    assign dn_data  = skid_data;
    assign dn_last  = skid_last;
    assign dn_port  = grant_q;
    assign busy     = (state_q != IDLE);
    assign skid_pop = skid_valid && dn_ready;
    // The byte read last cycle is on dout now; its EOD flag must stop a read this cycle.
    assign eod_now  = inflight_q && rx_eod[grant_q];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        inflight_d   = 1'b0;
        eod_done_d   = eod_done_q || eod_now;
        aborted_d    = aborted_q;
        wdog_d       = wdog_q;
        rd_en        = 1'b0;
        skid_push    = 1'b0;
        dn_abort     = 1'b0;
        found        = 1'b0;
        scan_idx     = '0;
        occ          = 3'(skid_occ) + 3'(inflight_q) - 3'(skid_pop);
        room         = (occ < 3'd2);

        case (state_q)
            IDLE: begin
                for (int k = 1; k <= NUM_PORTS; k++) begin
                    scan_idx = PORT_W'((int'(last_grant_q) + k) % NUM_PORTS);
                    if (!found && rx_frame_exist[scan_idx]) begin
                        found   = 1'b1;
                        grant_d = scan_idx;
                    end
                end
                if (found) begin
                    state_d    = XFER;
                    eod_done_d = 1'b0;
                    aborted_d  = 1'b0;
                    wdog_d     = '0;
                end
            end
            XFER: begin
                skid_push  = inflight_q;
                rd_en      = !rx_empty[grant_q] && !eod_done_q && !eod_now && room;
                inflight_d = rd_en;
                if (!eod_done_q && !eod_now) begin
                    if (rd_en) begin
                        wdog_d = '0;
                    end else if (rx_empty[grant_q]) begin
                        wdog_d = wdog_q + 16'd1;
                    end
                    if (wdog_d == 16'(TIMEOUT_CYC)) begin
                        state_d = DRAIN;
                    end
                end
                if (skid_pop && skid_last) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            DRAIN: begin
                // Buffered beats leave first; the abort follows once the skid is empty.
                if (!aborted_q) begin
                    if (skid_occ == 2'd0) begin
                        dn_abort  = 1'b1;
                        aborted_d = 1'b1;
                    end
                end else if (eod_done_q || eod_now) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end else begin
                    rd_en      = !rx_empty[grant_q];
                    inflight_d = rd_en;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= PORT_W'(NUM_PORTS - 1);
            inflight_q   <= 1'b0;
            eod_done_q   <= 1'b0;
            aborted_q    <= 1'b0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            inflight_q   <= inflight_d;
            eod_done_q   <= eod_done_d;
            aborted_q    <= aborted_d;
            wdog_q       <= wdog_d;
        end
    end

`ifdef RX_ARB_STATS_EN
    logic [STAT_W-1:0] frames_arr [NUM_PORTS];
    logic [STAT_W-1:0] aborts_arr [NUM_PORTS];
    logic [STAT_W-1:0] stat_frames_q, stat_frames_d;
    logic [STAT_W-1:0] stat_aborts_q, stat_aborts_d;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat
        logic [STAT_W-1:0] frames_q, frames_d;
        logic [STAT_W-1:0] aborts_q, aborts_d;

        always_comb begin
            frames_d = frames_q;
            aborts_d = aborts_q;
            if (skid_pop && skid_last && (grant_q == PORT_W'(g))) begin
                frames_d = sat_inc(frames_q);
            end
            if (dn_abort && (grant_q == PORT_W'(g))) begin
                aborts_d = sat_inc(aborts_q);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                frames_q <= '0;
                aborts_q <= '0;
            end else begin
                frames_q <= frames_d;
                aborts_q <= aborts_d;
            end
        end

        assign frames_arr[g] = frames_q;
        assign aborts_arr[g] = aborts_q;
    end

    always_comb begin
        stat_frames_d = frames_arr[stat_sel];
        stat_aborts_d = aborts_arr[stat_sel];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_frames_q <= '0;
            stat_aborts_q <= '0;
        end else begin
            stat_frames_q <= stat_frames_d;
            stat_aborts_q <= stat_aborts_d;
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_aborts = stat_aborts_q;
`endif

endmodule
